// File: rtl/fwd_hazard_if.sv
// ID-stage <-> forwarding/hazard unit bundle: the instruction in ID plus the
// resulting operand selects, stall request and stall-cycle count.
interface fwd_hazard_if #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [31:0]      inst_id;
  logic             flush;
  logic             stall_ext;
  logic [SEL_W-1:0] rs1_sel;
  logic [SEL_W-1:0] rs2_sel;
  logic             stall_id;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output inst_id, flush, stall_ext,
    input  rs1_sel, rs2_sel, stall_id, stall_cnt
  );

  modport slave (
    input  inst_id, flush, stall_ext,
    output rs1_sel, rs2_sel, stall_id, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding source select and load-use stall for the ID stage, backed by a
// DEPTH-entry shift pipeline of in-flight destination tags.
module fwd_src_match #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2
) (
  input  logic [4:0]            rs,
  input  logic                  used,
  input  logic [DEPTH-1:0]      tag_vld,
  input  logic [DEPTH-1:0]      tag_ld,
  input  logic [DEPTH-1:0][4:0] tag_rd,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);
  // Walk oldest to youngest so the youngest matching stage has the final say.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    if (used && rs != 5'd0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (tag_vld[k] && tag_rd[k] == rs) begin
          hazard = tag_ld[k] && (k < LOAD_LAT);
          sel    = hazard ? '0 : SEL_W'(k + 1);
        end
      end
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fwd_hazard_if.slave   hif
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_CSR       = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } tag_t;

  tag_t [DEPTH-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [6:0]        opc;
  logic [4:0]        rd;
  logic              has_rd;
  logic [1:0]        used;
  logic [1:0][4:0]   rs;
  logic [1:0][SEL_W-1:0] sel;
  logic [1:0]        haz;
  tag_t              dec_tag;
  logic [DEPTH-1:0]      tag_vld, tag_ld;
  logic [DEPTH-1:0][4:0] tag_rd;
  logic              stall;

  always_comb begin
    opc    = hif.inst_id[6:0];
    rd     = hif.inst_id[11:7];
    rs[0]  = hif.inst_id[19:15];
    rs[1]  = hif.inst_id[24:20];
    has_rd = 1'b0;
    unique case (opc)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_ARI_RTYPE, OP_ARI_ITYPE, OP_CSR: has_rd = (rd != 5'd0);
      default:                            has_rd = 1'b0;
    endcase
    used[0] = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    used[1] = (opc == OP_ARI_RTYPE || opc == OP_STORE || opc == OP_BRANCH);
    dec_tag = '{valid: has_rd, rd: rd, is_load: (opc == OP_LOAD)};
    for (int k = 0; k < DEPTH; k++) begin
      tag_vld[k] = tag_q[k].valid;
      tag_ld[k]  = tag_q[k].is_load;
      tag_rd[k]  = tag_q[k].rd;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_src
    fwd_src_match #(
      .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_match (
      .rs(rs[i]), .used(used[i]),
      .tag_vld(tag_vld), .tag_ld(tag_ld), .tag_rd(tag_rd),
      .sel(sel[i]), .hazard(haz[i])
    );
  end

  assign stall = (haz[0] | haz[1]) & ~hif.flush & ~rst;

  // A stalled or flushed ID instruction must not be seen downstream, so a bubble enters EX.
  always_comb begin
    tag_d = tag_q;
    cnt_d = cnt_q;
    if (!hif.stall_ext) begin
      for (int k = 1; k < DEPTH; k++) tag_d[k] = tag_q[k-1];
      tag_d[0] = (hif.flush || stall) ? '0 : dec_tag;
      if (stall) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign hif.rs1_sel   = sel[0];
  assign hif.rs2_sel   = sel[1];
  assign hif.stall_id  = stall;
  assign hif.stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed cycle-by-cycle vectors with a scoreboard queue and negedge monitor.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_if #(.DEPTH(2), .CNT_W(32)) bus ();

  fwd_hazard_unit #(.DEPTH(2), .LOAD_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hif(bus)
  );

  typedef struct {
    int          id;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3,
                                        logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rd,
                                        logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(logic [4:0] rs2, logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
    return enc_i(7'b0000011, 3'b010, rd, rs1, 12'd0);
  endfunction

  function automatic logic [31:0] add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return enc_r(7'd0, rd, rs1, rs2);
  endfunction

  task automatic step(input logic [31:0] inst, input logic fl, input logic se,
                      input logic r, input logic [1:0] e1, input logic [1:0] e2,
                      input logic es, input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    bus.inst_id   = inst;
    bus.flush     = fl;
    bus.stall_ext = se;
    rst           = r;
    e.id = step_no; e.s1 = e1; e.s2 = e2; e.st = es; e.cnt = ec;
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step%0d %s actual=%0h required=%0h", id, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "rs1_sel",   32'(bus.rs1_sel),  32'(e.s1));
      chk(e.id, "rs2_sel",   32'(bus.rs2_sel),  32'(e.s2));
      chk(e.id, "stall_id",  32'(bus.stall_id), 32'(e.st));
      chk(e.id, "stall_cnt", bus.stall_cnt,     e.cnt);
    end
  end

  initial begin
    logic [31:0] nop;
    nop = addi(5'd0, 5'd0, 12'd0);
    rst = 1'b1;
    bus.inst_id = nop; bus.flush = 1'b0; bus.stall_ext = 1'b0;
    repeat (2) @(posedge clk);

    //    inst                     fl se rst  s1 s2 st cnt
    step(nop,                      0, 0, 1,   0, 0, 0, 0);
    step(nop,                      0, 0, 0,   0, 0, 0, 0);
    // back-to-back ALU forward
    step(addi(5, 0, 3),            0, 0, 0,   0, 0, 0, 0);
    step(add(6, 5, 1),             0, 0, 0,   1, 0, 0, 0);
    // forward from the older stage, then youngest-wins
    step(addi(5, 0, 1),            0, 0, 0,   0, 0, 0, 0);
    step(nop,                      0, 0, 0,   0, 0, 0, 0);
    step(enc_r(7'h20, 7, 2, 5),    0, 0, 0,   0, 2, 0, 0);
    step(addi(5, 0, 1),            0, 0, 0,   0, 0, 0, 0);
    step(addi(5, 0, 2),            0, 0, 0,   0, 0, 0, 0);
    step(addi(8, 5, 0),            0, 0, 0,   1, 0, 0, 0);
    // load-use: one stall cycle then forward from index 1
    step(lw(5, 1),                 0, 0, 0,   0, 0, 0, 0);
    step(add(7, 5, 5),             0, 0, 0,   0, 0, 1, 0);
    step(add(7, 5, 5),             0, 0, 0,   2, 2, 0, 1);
    // x0 and non-writer cases
    step(addi(0, 0, 1),            0, 0, 0,   0, 0, 0, 1);
    step(add(3, 0, 0),             0, 0, 0,   0, 0, 0, 1);
    step(enc_sw(5, 9),             0, 0, 0,   0, 0, 0, 1);
    step(add(4, 5, 5),             0, 0, 0,   0, 0, 0, 1);
    step(addi(5, 0, 7),            0, 0, 0,   0, 0, 0, 1);
    step(enc_sw(2, 5),             0, 0, 0,   1, 0, 0, 1);
    // external freeze holds the forward
    step(addi(5, 0, 1),            0, 0, 0,   0, 0, 0, 1);
    step(add(6, 5, 0),             0, 1, 0,   1, 0, 0, 1);
    step(add(6, 5, 0),             0, 1, 0,   1, 0, 0, 1);
    step(add(6, 5, 0),             0, 1, 0,   1, 0, 0, 1);
    step(add(6, 5, 0),             0, 0, 0,   1, 0, 0, 1);
    // load-use under external freeze
    step(lw(9, 2),                 0, 0, 0,   0, 0, 0, 1);
    step(add(10, 9, 1),            0, 1, 0,   0, 0, 1, 1);
    step(add(10, 9, 1),            0, 1, 0,   0, 0, 1, 1);
    step(add(10, 9, 1),            0, 0, 0,   0, 0, 1, 1);
    step(add(10, 9, 1),            0, 0, 0,   2, 0, 0, 2);
    // flush beats a hazard and inserts a bubble
    step(lw(11, 2),                0, 0, 0,   0, 0, 0, 2);
    step(add(12, 11, 11),          1, 0, 0,   0, 0, 0, 2);
    step(add(13, 12, 11),          0, 0, 0,   0, 2, 0, 2);
    // reset during a load stall
    step(lw(14, 2),                0, 0, 0,   0, 0, 0, 2);
    step(add(15, 14, 13),          0, 0, 1,   0, 2, 0, 2);
    step(add(15, 14, 13),          0, 0, 0,   0, 0, 0, 0);
    step(add(16, 14, 14),          0, 0, 0,   0, 0, 0, 0);

    repeat (5) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
